// File: rtl/clk_tick_pkg.sv
// Shared timing constants for the tick divider bank
// and the game FSMs that consume its pulses.
package clk_tick_pkg;
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;
  localparam int   DEFAULT_TICK_PERIOD = 20;
endpackage

// File: rtl/clk_tick_chan.sv
// One divider channel: counter, live/shadow period,
// mode, start/stop state and a registered pulse.
module clk_tick_chan
  import clk_tick_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = DEFAULT_TICK_PERIOD,
  parameter int AUTO_START     = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             tick_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             oneshot_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] shd_per_q, shd_per_d;
  logic             os_q, os_d;
  logic             shd_os_q, shd_os_d;
  logic             pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic             wrap;

  assign wrap = busy_q && tick_i && (per_q != '0)
             && (cnt_q == per_q - CNT_W'(1));

  always_comb begin
    cnt_d     = cnt_q;
    per_d     = per_q;
    shd_per_d = shd_per_q;
    os_d      = os_q;
    shd_os_d  = shd_os_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    tick_d    = 1'b0;
    if (stop_i) begin
      busy_d = 1'b0;
      pend_d = 1'b0;
      if (we_i) begin
        per_d = period_i;
        os_d  = oneshot_i;
        cnt_d = '0;
      end else if (pend_q) begin
        per_d = shd_per_q;
        os_d  = shd_os_q;
      end
    end else if (start_i) begin
      cnt_d  = '0;
      busy_d = 1'b1;
      if (we_i) begin
        per_d  = period_i;
        os_d   = oneshot_i;
        pend_d = 1'b0;
      end
    end else if (!busy_q) begin
      if (we_i) begin
        per_d  = period_i;
        os_d   = oneshot_i;
        cnt_d  = '0;
        pend_d = 1'b0;
      end
    end else begin
      if (we_i) begin
        shd_per_d = period_i;
        shd_os_d  = oneshot_i;
        pend_d    = 1'b1;
      end
      // New config only lands on a wrap, so no period is cut short.
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        busy_d = (os_q != MODE_ONESHOT);
        if (we_i) begin
          per_d  = period_i;
          os_d   = oneshot_i;
          pend_d = 1'b0;
        end else if (pend_q) begin
          per_d  = shd_per_q;
          os_d   = shd_os_q;
          pend_d = 1'b0;
        end
      end else if (tick_i && per_q != '0) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      per_q     <= CNT_W'(DEFAULT_PERIOD);
      shd_per_q <= CNT_W'(DEFAULT_PERIOD);
      os_q      <= MODE_PERIODIC;
      shd_os_q  <= MODE_PERIODIC;
      pend_q    <= 1'b0;
      busy_q    <= (AUTO_START != 0);
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      shd_per_q <= shd_per_d;
      os_q      <= os_d;
      shd_os_q  <= shd_os_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = busy_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clk_tick_bank.sv
// Bank of programmable tick dividers sharing one
// base strobe; decodes config writes and muxes readback.
module clk_tick_bank
  import clk_tick_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int CH_W           = 2,
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = DEFAULT_TICK_PERIOD,
  parameter int AUTO_START     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_in,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic                cfg_oneshot,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  input  logic [CH_W-1:0]     rd_chan,
  output logic [CNT_W-1:0]    rd_count,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] tick_out
);

  logic [CNT_W-1:0] cnt_w [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic we;
    assign we = cfg_we && (cfg_chan == CH_W'(i));

    clk_tick_chan #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD),
      .AUTO_START     (AUTO_START)
    ) u_chan (
      .clk_i     (clk),
      .reset_i   (reset),
      .tick_i    (tick_in),
      .we_i      (we),
      .period_i  (cfg_period),
      .oneshot_i (cfg_oneshot),
      .start_i   (start[i]),
      .stop_i    (stop[i]),
      .cnt_o     (cnt_w[i]),
      .busy_o    (busy[i]),
      .tick_o    (tick_out[i])
    );
  end

  // Out-of-range selects read back as zero.
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_chan == CH_W'(i)) rd_count = cnt_w[i];
    end
  end

endmodule

// File: tb/tb_clk_tick_bank.sv
// Scoreboard bench for clk_tick_bank: directed
// stimulus queues expected pulses, monitor checks them.
module tb_clk_tick_bank;
  localparam int NCH = 4;
  localparam int CW  = 3;
  localparam int NW  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick_in = 1'b0;
  logic          cfg_we = 1'b0;
  logic [CW-1:0] cfg_chan = '0;
  logic [NW-1:0] cfg_period = '0;
  logic          cfg_oneshot = 1'b0;
  logic [NCH-1:0] start = '0;
  logic [NCH-1:0] stop = '0;
  logic [CW-1:0] rd_chan = '0;
  logic [NW-1:0] rd_count;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] tick_out;

  clk_tick_bank #(
    .CHANNELS(NCH), .CH_W(CW), .CNT_W(NW),
    .DEFAULT_PERIOD(20), .AUTO_START(1)
  ) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in),
    .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot),
    .start(start), .stop(stop), .rd_chan(rd_chan),
    .rd_count(rd_count), .busy(busy), .tick_out(tick_out)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int sc; } ev_t;
  ev_t q[$];
  int checks = 0;
  int errors = 0;
  int sc = 0;

  always @(posedge clk) if (tick_in && !reset) sc <= sc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (tick_out[i]) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL pulse: ch %0d at strobe %0d, none expected", i, sc);
        end else begin
          ev_t e;
          e = q.pop_front();
          if (e.ch != i || e.sc != sc) begin
            errors++;
            $display("FAIL pulse: got ch %0d strobe %0d, want ch %0d strobe %0d",
                     i, sc, e.ch, e.sc);
          end
        end
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic push(int ch, int s);
    ev_t e;
    e.ch = ch;
    e.sc = s;
    q.push_back(e);
  endtask

  task automatic strobe(int n, int gap);
    for (int k = 0; k < n; k++) begin
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic cfg(int ch, int p, logic os, logic [NCH-1:0] st);
    cfg_we = 1'b1;
    cfg_chan = CW'(ch);
    cfg_period = NW'(p);
    cfg_oneshot = os;
    start = st;
    @(negedge clk);
    cfg_we = 1'b0;
    start = '0;
  endtask

  task automatic pulse_ss(logic [NCH-1:0] st, logic [NCH-1:0] sp);
    start = st;
    stop = sp;
    @(negedge clk);
    start = '0;
    stop = '0;
  endtask

  task automatic rd(int ch, int exp, string nm);
    rd_chan = CW'(ch);
    #1;
    chk(nm, int'(rd_count), exp);
  endtask

  int s;

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 15);
    chk("reset_tick", int'(tick_out), 0);
    rd(0, 0, "reset_cnt0");
    rd(3, 0, "reset_cnt3");
    reset = 1'b0;
    @(negedge clk);

    // default period 20, all channels auto-started
    for (int k = 1; k <= 2; k++)
      for (int c = 0; c < NCH; c++) push(c, 20 * k);
    strobe(40, 5);
    pulse_ss('0, 4'hF);
    chk("stop_all", int'(busy), 0);

    // one-shot P=3 on ch1
    s = sc;
    cfg(1, 3, 1'b1, '0);
    pulse_ss(4'b0010, '0);
    push(1, s + 3);
    strobe(2, 1);
    chk("os_busy_mid", int'(busy[1]), 1);
    rd(1, 2, "os_cnt_mid");
    strobe(1, 1);
    chk("os_busy_fall", int'(busy[1]), 0);
    strobe(5, 3);

    // ch2 P=10, retune to 4 at cnt 6
    cfg(2, 10, 1'b0, '0);
    pulse_ss(4'b0100, '0);
    s = sc;
    strobe(6, 3);
    rd(2, 6, "retune_cnt");
    cfg(2, 4, 1'b0, '0);
    push(2, s + 10);
    push(2, s + 14);
    push(2, s + 18);
    strobe(12, 3);
    pulse_ss('0, 4'b0100);

    // ch3 start/stop priority and start on wrap strobe
    cfg(3, 5, 1'b0, '0);
    pulse_ss(4'b1000, '0);
    strobe(2, 2);
    pulse_ss(4'b1000, 4'b1000);
    chk("stop_wins", int'(busy[3]), 0);
    rd(3, 2, "stop_hold");
    pulse_ss(4'b1000, '0);
    strobe(4, 2);
    tick_in = 1'b1;
    pulse_ss(4'b1000, '0);
    tick_in = 1'b0;
    rd(3, 0, "start_on_wrap");
    chk("start_wrap_busy", int'(busy[3]), 1);
    push(3, sc + 5);
    strobe(5, 2);
    pulse_ss('0, 4'b1000);

    // ch0 P=0 never fires, then P=1 fires every strobe
    cfg(0, 0, 1'b0, 4'b0001);
    strobe(1000, 2);
    rd(0, 0, "p0_cnt");
    chk("p0_busy", int'(busy[0]), 1);
    cfg(0, 1, 1'b0, 4'b0001);
    s = sc;
    for (int k = 1; k <= 5; k++) push(0, s + k);
    strobe(5, 2);
    pulse_ss('0, 4'b0001);

    // reset on a wrap strobe, then out-of-range config
    cfg(1, 3, 1'b0, 4'b0010);
    strobe(2, 2);
    rd(1, 2, "pre_reset_cnt");
    reset = 1'b1;
    tick_in = 1'b1;
    @(negedge clk);
    tick_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_busy", int'(busy), 15);
    chk("rst2_tick", int'(tick_out), 0);
    rd(1, 0, "rst2_cnt1");
    cfg(4, 2, 1'b1, '0);
    rd(2, 0, "oob_cnt2");
    s = sc;
    for (int c = 0; c < NCH; c++) push(c, s + 20);
    strobe(20, 2);
    chk("oob_busy", int'(busy), 15);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
